// File: rtl/sma_decim_fifo.sv
// Decimator and output FIFO behind the 4-tap moving-average filter: keeps every
// DECIM-th valid sample and buffers it for a valid/ready sink.
module sma_decim_fifo #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_en,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out_data,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
  localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);

  logic [PW-1:0]            phase;
  logic [AW-1:0]            rd_ptr;
  logic [AW-1:0]            wr_ptr;
  logic signed [DATA_W-1:0] mem [DEPTH];

  logic keep;
  logic pop;
  logic full;
  logic push;
  logic drop;

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    keep = cfg_en & in_valid & (phase == PH_LAST);
    pop  = out_valid & out_ready;
    full = (level == FULL);
    push = keep & (~full | pop);
    drop = keep & full & ~pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (!cfg_en) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= keep ? '0 : phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_comb begin
    out_valid = (level != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_sma_decim_fifo.sv
// Scoreboard bench for sma_decim_fifo: one DECIM=4 and one DECIM=1 instance
// checked against a queue-based model of the keep/buffer/drop rules.
module tb_sma_decim_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                 en_s  [2];
  logic                 v_s   [2];
  logic                 rdy_s [2];
  logic                 clr_s [2];
  logic signed [DW-1:0] d_s   [2];
  logic                 ov    [2];
  logic                 of    [2];
  logic signed [DW-1:0] od    [2];
  logic [2:0]           lv    [2];

  sma_decim_fifo #(.DATA_W(DW), .DECIM(4), .DEPTH(DEPTH)) u_d4 (
    .clk(clk), .rst(rst), .cfg_en(en_s[0]), .in_valid(v_s[0]), .in_data(d_s[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(rdy_s[0]), .level(lv[0]),
    .overflow(of[0]), .ovf_clr(clr_s[0])
  );

  sma_decim_fifo #(.DATA_W(DW), .DECIM(1), .DEPTH(DEPTH)) u_d1 (
    .clk(clk), .rst(rst), .cfg_en(en_s[1]), .in_valid(v_s[1]), .in_data(d_s[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(rdy_s[1]), .level(lv[1]),
    .overflow(of[1]), .ovf_clr(clr_s[1])
  );

  // Reference model: FIFO contents, expected handshake stream, sample count.
  logic [DW-1:0] mq    [2][$];
  logic [DW-1:0] exp_q [2][$];
  int            cnt     [2];
  bit            movf    [2];
  int            snap_lv [2];
  bit            snap_ovf[2];
  int            n_chk = 0;
  int            n_fail = 0;

  function automatic int dec(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input int k, input logic [DW-1:0] act,
                     input logic [DW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s [decim=%0d] at %0t: got %0h expected %0h",
               name, dec(k), $time, act, expv);
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      en_s[k] = 1'b1; v_s[k] = 1'b0; d_s[k] = '0; rdy_s[k] = 1'b1; clr_s[k] = 1'b0;
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drive(input int k, input bit en, input bit v, input logic [DW-1:0] d,
                       input bit rdy, input bit clr);
    en_s[k] = en; v_s[k] = v; d_s[k] = d; rdy_s[k] = rdy; clr_s[k] = clr;
  endtask

  // Applies the rules for the upcoming edge; snapshots the state after the last edge.
  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      bit pop, keep, drop;
      snap_lv[k]  = mq[k].size();
      snap_ovf[k] = movf[k];
      pop  = rdy_s[k] && (mq[k].size() != 0);
      keep = en_s[k] && v_s[k] && ((cnt[k] % dec(k)) == dec(k) - 1);
      if (!en_s[k])    cnt[k] = 0;
      else if (v_s[k]) cnt[k]++;
      if (pop) void'(mq[k].pop_front());
      drop = 1'b0;
      if (keep) begin
        if (mq[k].size() < DEPTH) begin
          mq[k].push_back(d_s[k]);
          exp_q[k].push_back(d_s[k]);
        end else begin
          drop = 1'b1;
        end
      end
      if (drop)          movf[k] = 1'b1;
      else if (clr_s[k]) movf[k] = 1'b0;
    end
  endtask

  task automatic one(input int k, input bit en, input bit v, input logic [DW-1:0] d,
                     input bit rdy, input bit clr);
    sync();
    drive(k, en, v, d, rdy, clr);
    commit();
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      sync();
      rdy_s[0] = rdy; rdy_s[1] = rdy;
      commit();
    end
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk);
    #3;
    rst = 1'b0;
    idle();
    #1;
    if (check) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_level", k, 16'(lv[k]), '0);
        chk("rst_out_valid", k, 16'(ov[k]), '0);
        chk("rst_out_data", k, od[k], '0);
        chk("rst_overflow", k, 16'(of[k]), '0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      mq[k].delete(); exp_q[k].delete();
      cnt[k] = 0; movf[k] = 1'b0; snap_lv[k] = 0; snap_ovf[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("level", k, 16'(lv[k]), 16'(snap_lv[k]));
        chk("out_valid", k, 16'(ov[k]), 16'(snap_lv[k] != 0));
        chk("overflow", k, 16'(of[k]), 16'(snap_ovf[k]));
        if (snap_lv[k] == 0) chk("out_data_empty", k, od[k], '0);
        if (ov[k] && rdy_s[k]) begin
          if (exp_q[k].size() == 0) chk("unexpected_output", k, 16'd1, 16'd0);
          else chk("out_data", k, od[k], exp_q[k].pop_front());
        end
      end
    end
  end

  initial begin
    idle();
    do_reset(1'b1);

    // Every 4th sample of 1..12.
    for (int i = 1; i <= 12; i++) one(0, 1, 1, 16'(i), 1, 0);
    idle_cycles(3, 1);

    // Sign bit preserved.
    one(1, 1, 1, 16'h8000, 1, 0);
    one(1, 1, 1, 16'hFFFF, 1, 0);
    one(1, 1, 1, 16'h7FFF, 1, 0);
    idle_cycles(3, 1);

    // Fill then overflow; 50 is lost.
    for (int i = 1; i <= 5; i++) one(1, 1, 1, 16'(10 * i), 0, 0);
    idle_cycles(2, 0);
    idle_cycles(6, 1);
    one(1, 1, 0, '0, 1, 1);

    // Full FIFO with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) one(1, 1, 1, 16'(i), 0, 0);
    one(1, 1, 1, 16'd5, 1, 0);
    idle_cycles(6, 1);

    // cfg_en gating restarts the sample count.
    one(0, 1, 1, 16'd100, 1, 0);
    one(0, 1, 1, 16'd101, 1, 0);
    for (int i = 0; i < 3; i++) one(0, 0, 1, 16'(110 + i), 1, 0);
    for (int i = 0; i < 4; i++) one(0, 1, 1, 16'(200 + i), 1, 0);
    idle_cycles(3, 1);

    // Drop and clear in the same cycle: set wins; clear alone next cycle.
    for (int i = 0; i < 4; i++) one(1, 1, 1, 16'(60 + i), 0, 0);
    one(1, 1, 1, 16'd64, 0, 1);
    one(1, 1, 0, '0, 0, 1);
    idle_cycles(1, 0);
    idle_cycles(6, 1);

    // Asynchronous reset with three entries buffered.
    for (int i = 0; i < 3; i++) one(1, 1, 1, 16'(70 + i), 0, 0);
    one(1, 1, 0, '0, 0, 0);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) one(0, 1, 1, 16'(300 + i), 1, 0);
    idle_cycles(3, 1);

    // Random traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      sync();
      for (int k = 0; k < 2; k++)
        drive(k, ($urandom % 8) != 0, ($urandom % 4) != 0, 16'($urandom),
              ($urandom % 3) != 0, ($urandom % 16) == 0);
      commit();
    end
    idle_cycles(10, 1);

    for (int k = 0; k < 2; k++) chk("drain_pending", k, 16'(exp_q[k].size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
